// File: rtl/mem_commit_unit.sv
// mem_commit_unit: data-memory access engine behind the ROB commit port (rv32i loads/stores).
// Optional misaligned-access trap is enabled by defining MEM_MISALIGN_CHECK_EN.
module mem_commit_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_read,
  input  logic        data_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_mem_resp,
  output logic [31:0] ld_data,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic        misaligned
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  funct3_p0;
  logic [1:0]  off_p0;
  logic        accept;
  logic        mis_now;

  // funct3[1:0] selects size; anything that is not B or H behaves as a word.
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_mask = 4'b0001 << off;
      2'b01:   store_mask = 4'b0011 << {off[1], 1'b0};
      default: store_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    case (f3[1:0])
      2'b00:   store_data = {4{wd[7:0]}};
      2'b01:   store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] rdata);
    logic [31:0] byte_sh;
    logic [31:0] half_sh;
    byte_sh = rdata >> {off, 3'b000};
    half_sh = rdata >> {off[1], 4'b0000};
    case (f3)
      3'b000:  load_extend = {{24{byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_extend = {{16{half_sh[15]}}, half_sh[15:0]};
      3'b100:  load_extend = {24'd0, byte_sh[7:0]};
      3'b101:  load_extend = {16'd0, half_sh[15:0]};
      default: load_extend = rdata;
    endcase
  endfunction

`ifdef MEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  logic mis_p1;

  // Only a trapped access jumps IDLE -> DONE, so that transition marks the fault.
  always_ff @(posedge clk) begin
    if (rst) mis_p1 <= 1'b0;
    else     mis_p1 <= (state == IDLE) && (state_next == DONE);
  end

  assign mis_now    = is_misaligned(funct3, addr[1:0]);
  assign misaligned = mis_p1;
`else
  assign mis_now    = 1'b0;
  assign misaligned = 1'b0;
`endif

  assign accept = (state == IDLE) && (data_read || data_write);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (data_read || data_write) begin
          if (mis_now)        state_next = DONE;
          else if (data_read) state_next = READ;
          else                state_next = WRITE;
        end
      end
      READ:    if (dmem_resp) state_next = DONE;
      WRITE:   if (dmem_resp) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are flops loaded from the next state so every port is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dmem_read     <= 1'b0;
      dmem_write    <= 1'b0;
      data_mem_resp <= 1'b0;
      dmem_address  <= '0;
      dmem_wmask    <= '0;
      dmem_wdata    <= '0;
      ld_data       <= '0;
      funct3_p0     <= '0;
      off_p0        <= '0;
    end else begin
      state         <= state_next;
      dmem_read     <= (state_next == READ);
      dmem_write    <= (state_next == WRITE);
      data_mem_resp <= (state_next == DONE);
      if (accept) begin
        dmem_address <= {addr[31:2], 2'b00};
        dmem_wmask   <= store_mask(funct3, addr[1:0]);
        dmem_wdata   <= store_data(funct3, wdata);
        funct3_p0    <= funct3;
        off_p0       <= addr[1:0];
        ld_data      <= '0;
      end
      if (state == READ && dmem_resp)
        ld_data <= load_extend(funct3_p0, off_p0, dmem_rdata);
    end
  end

  // The ROB never presents a load and a store at the head simultaneously.
  a_single_request: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE) |-> !(data_read && data_write));

endmodule

// File: tb/tb_mem_commit_unit.sv
// Self-checking bench for mem_commit_unit: directed plan cases plus randomized loads/stores
// checked against a byte-lane reference model.
module tb_mem_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        data_read, data_write;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        data_mem_resp;
  logic [31:0] ld_data, dmem_address;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata, dmem_rdata;
  logic        dmem_resp;
  logic        misaligned;

  int checks = 0;
  int errors = 0;

  mem_commit_unit dut (
    .clk(clk), .rst(rst), .data_read(data_read), .data_write(data_write),
    .funct3(funct3), .addr(addr), .wdata(wdata), .data_mem_resp(data_mem_resp),
    .ld_data(ld_data), .dmem_address(dmem_address), .dmem_read(dmem_read),
    .dmem_write(dmem_write), .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  // Reference model: access described as a byte span [start, start+size) of the word.
  function automatic int size_of(input logic [2:0] f3);
    if (f3 == 3'd0 || f3 == 3'd4) return 1;
    if (f3 == 3'd1 || f3 == 3'd5) return 2;
    return 4;
  endfunction

  function automatic int start_of(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    if (sz == 1) return int'(a[1:0]);
    if (sz == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic bit exp_mis(input logic [2:0] f3, input logic [31:0] a);
`ifdef MEM_MISALIGN_CHECK_EN
    int sz = size_of(f3);
    return (sz == 2 && a[0]) || (sz == 4 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz = size_of(f3);
    int st = start_of(f3, a);
    logic [31:0] v = 32'd0;
    if (exp_mis(f3, a)) return 32'd0;
    for (int i = 0; i < sz; i++) v = v | (32'(rd[8*(st+i) +: 8]) << (8*i));
    if ((f3 == 3'd0 || f3 == 3'd1) && v[8*sz-1])
      for (int i = 8*sz; i < 32; i++) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] exp_mask(input logic [2:0] f3, input logic [31:0] a);
    int sz = size_of(f3);
    int st = start_of(f3, a);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i >= st) && (i < st + sz);
    return m;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz = size_of(f3);
    logic [31:0] d;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wd[8*(i % sz) +: 8];
    return d;
  endfunction

  // Observations of one access
  int          o_lat, o_rd, o_wr;
  logic [31:0] o_addr, o_wdata, o_ld;
  logic [3:0]  o_mask;
  logic        o_mis;
  bit          o_pulse_ok, o_timeout;

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after DONE.
  task automatic run_access(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, input logic [31:0] rd, input int waits);
    int  waited = 0;
    bit  seen = 0;
    o_lat = -1; o_rd = 0; o_wr = 0; o_addr = '0; o_mask = '0; o_wdata = '0; o_ld = '0;
    o_mis = 1'b0; o_pulse_ok = 0; o_timeout = 1;
    data_read = !wr; data_write = wr; funct3 = f3; addr = a; wdata = wd; dmem_resp = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (data_mem_resp) begin
        o_lat = c; o_ld = ld_data; o_mis = misaligned;
        data_read = 1'b0; data_write = 1'b0; dmem_resp = 1'b0;
        @(negedge clk);
        o_pulse_ok = !data_mem_resp && !dmem_read && !dmem_write;
        o_timeout = 0;
        break;
      end
      if (dmem_read)  o_rd++;
      if (dmem_write) o_wr++;
      if ((dmem_read || dmem_write) && !seen) begin
        seen = 1; o_addr = dmem_address; o_mask = dmem_wmask; o_wdata = dmem_wdata;
      end
      if (dmem_read || dmem_write) begin
        if (waited == waits) begin dmem_resp = 1'b1; dmem_rdata = rd; end
        else begin dmem_resp = 1'b0; dmem_rdata = $urandom; waited++; end
      end else dmem_resp = 1'b0;
    end
    if (o_timeout) begin data_read = 1'b0; data_write = 1'b0; dmem_resp = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({dmem_read, dmem_write, data_mem_resp, misaligned} !== 4'b0000) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0000",
                         {dmem_read, dmem_write, data_mem_resp, misaligned});
    end
    checks++;
    if (dmem_address !== 32'd0 || dmem_wmask !== 4'd0) begin
      errors++; $display("FAIL reset_addr_mask: got %h/%b required 0/0", dmem_address, dmem_wmask);
    end
    checks++;
    if (dmem_wdata !== 32'd0 || ld_data !== 32'd0) begin
      errors++; $display("FAIL reset_data: got %h/%h required 0/0", dmem_wdata, ld_data);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw_wait();
    run_access(1'b0, 3'b010, 32'h100, 32'd0, 32'hDEADBEEF, 2);
    checks++;
    if (o_timeout || o_lat != 4) begin
      errors++; $display("FAIL lw_latency: got %0d required 4", o_lat);
    end
    checks++;
    if (o_rd != 3 || o_wr != 0) begin
      errors++; $display("FAIL lw_read_cycles: got rd=%0d wr=%0d required rd=3 wr=0", o_rd, o_wr);
    end
    checks++;
    if (o_addr !== 32'h100) begin
      errors++; $display("FAIL lw_addr: got %h required 00000100", o_addr);
    end
    checks++;
    if (o_ld !== 32'hDEADBEEF || !o_pulse_ok) begin
      errors++; $display("FAIL lw_data: got %h pulse_ok=%0d required deadbeef pulse_ok=1",
                         o_ld, o_pulse_ok);
    end
  endtask

  task automatic test_lb_lbu();
    run_access(1'b0, 3'b000, 32'h103, 32'd0, 32'h80FF1234, 1);
    checks++;
    if (o_timeout || o_ld !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_sign: got %h required ffffff80", o_ld);
    end
    run_access(1'b0, 3'b100, 32'h103, 32'd0, 32'h80FF1234, 0);
    checks++;
    if (o_timeout || o_ld !== 32'h00000080) begin
      errors++; $display("FAIL lbu_zero: got %h required 00000080", o_ld);
    end
  endtask

  task automatic test_sb_sh();
    run_access(1'b1, 3'b000, 32'h102, 32'h000000AB, 32'd0, 1);
    checks++;
    if (o_timeout || o_mask !== 4'b0100 || o_wdata !== 32'hABABABAB || o_addr !== 32'h100) begin
      errors++; $display("FAIL sb_format: got mask=%b data=%h addr=%h required 0100 abababab 00000100",
                         o_mask, o_wdata, o_addr);
    end
    checks++;
    if (o_wr != 2 || o_rd != 0) begin
      errors++; $display("FAIL sb_write_cycles: got wr=%0d rd=%0d required wr=2 rd=0", o_wr, o_rd);
    end
    run_access(1'b1, 3'b001, 32'h102, 32'h0000BEEF, 32'd0, 0);
    checks++;
    if (o_timeout || o_mask !== 4'b1100 || o_wdata !== 32'hBEEFBEEF) begin
      errors++; $display("FAIL sh_format: got mask=%b data=%h required 1100 beefbeef", o_mask, o_wdata);
    end
  endtask

  task automatic test_back_to_back();
    run_access(1'b1, 3'b010, 32'h200, 32'h12345678, 32'd0, 0);
    checks++;
    if (o_timeout || o_lat != 2 || !o_pulse_ok || o_wdata !== 32'h12345678) begin
      errors++; $display("FAIL b2b_sw: got lat=%0d pulse_ok=%0d data=%h required 2 1 12345678",
                         o_lat, o_pulse_ok, o_wdata);
    end
    run_access(1'b0, 3'b010, 32'h200, 32'd0, 32'hCAFEF00D, 0);
    checks++;
    if (o_timeout || o_lat != 2 || !o_pulse_ok || o_ld !== 32'hCAFEF00D) begin
      errors++; $display("FAIL b2b_lw: got lat=%0d pulse_ok=%0d ld=%h required 2 1 cafef00d",
                         o_lat, o_pulse_ok, o_ld);
    end
  endtask

  task automatic test_rst_mid();
    data_read = 1'b1; funct3 = 3'b010; addr = 32'h300; dmem_resp = 1'b0;
    @(negedge clk);
    checks++;
    if (dmem_read !== 1'b1) begin
      errors++; $display("FAIL rst_mid_pre: got dmem_read=%b required 1", dmem_read);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dmem_read !== 1'b0 || dmem_address !== 32'd0 || data_mem_resp !== 1'b0) begin
      errors++; $display("FAIL rst_mid_clear: got read=%b addr=%h resp=%b required 0 0 0",
                         dmem_read, dmem_address, data_mem_resp);
    end
    data_read = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'h55555555;
    @(negedge clk);
    dmem_resp = 1'b0;
    checks++;
    if (data_mem_resp !== 1'b0 || dmem_read !== 1'b0) begin
      errors++; $display("FAIL rst_late_resp: got resp=%b read=%b required 0 0", data_mem_resp, dmem_read);
    end
    @(negedge clk);
  endtask

  task automatic test_misalign_w();
    run_access(1'b0, 3'b010, 32'h102, 32'd0, 32'h0BADF00D, 0);
`ifdef MEM_MISALIGN_CHECK_EN
    checks++;
    if (o_timeout || o_lat != 1 || o_rd != 0 || o_mis !== 1'b1 || o_ld !== 32'd0) begin
      errors++; $display("FAIL misalign_lw: got lat=%0d rd=%0d mis=%b ld=%h required 1 0 1 0",
                         o_lat, o_rd, o_mis, o_ld);
    end
`else
    checks++;
    if (o_timeout || o_addr !== 32'h100 || o_mis !== 1'b0 || o_ld !== 32'h0BADF00D) begin
      errors++; $display("FAIL unaligned_lw: got addr=%h mis=%b ld=%h required 00000100 0 0badf00d",
                         o_addr, o_mis, o_ld);
    end
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      bit          wr  = 1'($urandom_range(0, 1));
      logic [2:0]  f3  = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      int          w   = $urandom_range(0, 3);
      bit          mis = exp_mis(f3, a);
      run_access(wr, f3, a, wd, rd, w);
      checks++;
      if (o_timeout || o_lat != (mis ? 1 : w + 2) || !o_pulse_ok) begin
        errors++; $display("FAIL rnd_timing[%0d]: got lat=%0d pulse_ok=%0d required lat=%0d pulse_ok=1",
                           n, o_lat, o_pulse_ok, mis ? 1 : w + 2);
      end
      checks++;
      if (o_rd != ((!wr && !mis) ? w + 1 : 0) || o_wr != ((wr && !mis) ? w + 1 : 0)) begin
        errors++; $display("FAIL rnd_req_cycles[%0d]: got rd=%0d wr=%0d", n, o_rd, o_wr);
      end
      checks++;
      if (o_mis !== mis) begin
        errors++; $display("FAIL rnd_misaligned[%0d]: got %b required %b", n, o_mis, mis);
      end
      if (!mis) begin
        checks++;
        if (o_addr !== {a[31:2], 2'b00}) begin
          errors++; $display("FAIL rnd_addr[%0d]: got %h required %h", n, o_addr, {a[31:2], 2'b00});
        end
      end
      if (wr && !mis) begin
        checks++;
        if (o_mask !== exp_mask(f3, a) || o_wdata !== exp_wdata(f3, wd)) begin
          errors++; $display("FAIL rnd_store[%0d]: got mask=%b data=%h required mask=%b data=%h",
                             n, o_mask, o_wdata, exp_mask(f3, a), exp_wdata(f3, wd));
        end
      end
      if (!wr) begin
        checks++;
        if (o_ld !== exp_load(f3, a, rd)) begin
          errors++; $display("FAIL rnd_load[%0d]: f3=%b addr=%h rdata=%h got %h required %h",
                             n, f3, a, rd, o_ld, exp_load(f3, a, rd));
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; data_read = 1'b0; data_write = 1'b0; funct3 = 3'd0; addr = '0; wdata = '0;
    dmem_rdata = '0; dmem_resp = 1'b0;
    @(negedge clk);
    test_reset();
    test_lw_wait();
    test_lb_lbu();
    test_sb_sh();
    test_back_to_back();
    test_rst_mid();
    test_misalign_w();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
